// File: rtl/cram_dump_reader_pkg.sv
// Shared definitions for readers of the CPU RAM display port: the dump FSM state
// encodings and the synchronous read latency of the display port.
package cram_dump_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_LATCH = 2'd2,
        ST_VALID = 2'd3
    } dump_state_t;

    // Cycles from presenting a display address until the RAM output holds that word.
    localparam int unsigned DispReadLatency = 1;

endpackage

// File: rtl/cram_dump_reader.sv
// Walks a contiguous range of the CPU RAM display port and streams each word,
// tagged with its address, over a valid/ready interface.
module cram_dump_reader
    import cram_dump_reader_pkg::*;
#(
    parameter int p_data_width    = 16,
    parameter int p_address_width = 10
) (
    input  logic                       i_w_clk,
    input  logic                       i_w_reset,
    input  logic                       i_w_start,
    input  logic                       i_w_abort,
    input  logic [p_address_width-1:0] i_w_base_address,
    input  logic [p_address_width:0]   i_w_count,
    output logic [p_address_width-1:0] o_w_disp_address,
    input  logic [p_data_width-1:0]    i_w_disp_out,
    output logic [p_data_width-1:0]    o_r_data,
    output logic [p_address_width-1:0] o_r_address,
    output logic                       o_r_valid,
    input  logic                       i_w_ready,
    output logic                       o_r_busy,
    output logic                       o_r_done
);

    localparam logic [p_address_width:0]   CountOne = (p_address_width+1)'(1);
    localparam logic [p_address_width-1:0] AddrOne  = p_address_width'(1);

    dump_state_t              state_q;
    logic [p_address_width:0] remaining_q;

    // LATCH captures the RAM output one cycle after READ, matching DispReadLatency.
    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            state_q          <= ST_IDLE;
            remaining_q      <= '0;
            o_w_disp_address <= '0;
            o_r_data         <= '0;
            o_r_address      <= '0;
            o_r_valid        <= 1'b0;
            o_r_busy         <= 1'b0;
            o_r_done         <= 1'b0;
        end else begin
            o_r_done <= 1'b0;
            if (i_w_abort) begin
                state_q          <= ST_IDLE;
                remaining_q      <= '0;
                o_w_disp_address <= '0;
                o_r_data         <= '0;
                o_r_address      <= '0;
                o_r_valid        <= 1'b0;
                o_r_busy         <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (i_w_start) begin
                            if (i_w_count == '0) begin
                                o_r_done <= 1'b1;
                            end else begin
                                o_w_disp_address <= i_w_base_address;
                                remaining_q      <= i_w_count;
                                o_r_busy         <= 1'b1;
                                state_q          <= ST_READ;
                            end
                        end
                    end
                    ST_READ: begin
                        state_q <= ST_LATCH;
                    end
                    ST_LATCH: begin
                        o_r_data    <= i_w_disp_out;
                        o_r_address <= o_w_disp_address;
                        o_r_valid   <= 1'b1;
                        state_q     <= ST_VALID;
                    end
                    ST_VALID: begin
                        if (i_w_ready) begin
                            o_r_valid   <= 1'b0;
                            remaining_q <= remaining_q - CountOne;
                            if (remaining_q == CountOne) begin
                                o_r_done <= 1'b1;
                                o_r_busy <= 1'b0;
                                state_q  <= ST_IDLE;
                            end else begin
                                o_w_disp_address <= o_w_disp_address + AddrOne;
                                state_q          <= ST_READ;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cram_dump_reader.sv
// Directed bench for cram_dump_reader against a behavioural model of the RAM
// display port preloaded with word[n] = n ^ 16'hA5A5.
module tb_cram_dump_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [9:0]  baseAddress;
    logic [10:0] count;
    logic [9:0]  dispAddress;
    logic [15:0] dispOut;
    logic [15:0] rData;
    logic [9:0]  rAddress;
    logic        rValid;
    logic        ready;
    logic        rBusy;
    logic        rDone;

    logic [15:0] mem [1024];

    int checkCount;
    int errorCount;

    logic [9:0]  hsAddr [$];
    logic [15:0] hsData [$];
    int          doneCount;
    int          timedOut;

    cram_dump_reader #(
        .p_data_width    (16),
        .p_address_width (10)
    ) dut (
        .i_w_clk          (clk),
        .i_w_reset        (reset),
        .i_w_start        (start),
        .i_w_abort        (abort),
        .i_w_base_address (baseAddress),
        .i_w_count        (count),
        .o_w_disp_address (dispAddress),
        .i_w_disp_out     (dispOut),
        .o_r_data         (rData),
        .o_r_address      (rAddress),
        .o_r_valid        (rValid),
        .i_w_ready        (ready),
        .o_r_busy         (rBusy),
        .o_r_done         (rDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) dispOut <= mem[dispAddress];

    // Leaves the caller at the falling edge of cycle 1 (start accepted at edge 0).
    task automatic do_start(input logic [9:0] base, input logic [10:0] cnt);
        baseAddress = base;
        count       = cnt;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    // Records handshakes and done pulses; optionally injects a junk start at one cycle.
    task automatic run_collect(input int maxCycles, input int injectCycle);
        hsAddr.delete();
        hsData.delete();
        doneCount = 0;
        timedOut  = 1;
        for (int c = 1; c <= maxCycles; c++) begin
            if (rValid && ready) begin
                hsAddr.push_back(rAddress);
                hsData.push_back(rData);
            end
            if (rDone) doneCount++;
            if (c == injectCycle) begin
                baseAddress = 10'h200;
                count       = 11'd7;
                start       = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (rDone) begin
                timedOut = 0;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
        if (rDone) doneCount++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkCount++;
        if (rValid !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_valid got %b expected 0", rValid); end
        checkCount++;
        if (rBusy !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_busy got %b expected 0", rBusy); end
        checkCount++;
        if (rDone !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_done got %b expected 0", rDone); end
        checkCount++;
        if (rData !== 16'h0) begin errorCount++; $display("[TB] FAIL reset_data got %h expected 0000", rData); end
        checkCount++;
        if (rAddress !== 10'h0) begin errorCount++; $display("[TB] FAIL reset_address got %h expected 000", rAddress); end
        checkCount++;
        if (dispAddress !== 10'h0) begin errorCount++; $display("[TB] FAIL reset_disp_address got %h expected 000", dispAddress); end
    endtask

    task automatic test_basic();
        logic        expValid;
        logic        expBusy;
        logic        expDone;
        logic [9:0]  expAddr;
        logic [15:0] expData;
        int          word;
        ready = 1'b1;
        word  = 0;
        do_start(10'h010, 11'd3);
        for (int c = 1; c <= 11; c++) begin
            expValid = (c == 3) || (c == 6) || (c == 9);
            expBusy  = (c <= 9);
            expDone  = (c == 10);
            checkCount++;
            if (rValid !== expValid) begin errorCount++; $display("[TB] FAIL basic_valid cycle %0d got %b expected %b", c, rValid, expValid); end
            checkCount++;
            if (rBusy !== expBusy) begin errorCount++; $display("[TB] FAIL basic_busy cycle %0d got %b expected %b", c, rBusy, expBusy); end
            checkCount++;
            if (rDone !== expDone) begin errorCount++; $display("[TB] FAIL basic_done cycle %0d got %b expected %b", c, rDone, expDone); end
            if (expValid) begin
                expAddr = 10'h010 + 10'(word);
                expData = {6'b0, expAddr} ^ 16'hA5A5;
                checkCount++;
                if (rAddress !== expAddr) begin errorCount++; $display("[TB] FAIL basic_address word %0d got %h expected %h", word, rAddress, expAddr); end
                checkCount++;
                if (rData !== expData) begin errorCount++; $display("[TB] FAIL basic_data word %0d got %h expected %h", word, rData, expData); end
                word++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        logic [9:0] expAddr [4];
        expAddr[0] = 10'h3FE;
        expAddr[1] = 10'h3FF;
        expAddr[2] = 10'h000;
        expAddr[3] = 10'h001;
        ready = 1'b1;
        do_start(10'h3FE, 11'd4);
        run_collect(100, 0);
        checkCount++;
        if (timedOut !== 0) begin errorCount++; $display("[TB] FAIL wrap_timeout got %0d expected 0", timedOut); end
        checkCount++;
        if (hsAddr.size() !== 4) begin errorCount++; $display("[TB] FAIL wrap_handshakes got %0d expected 4", hsAddr.size()); end
        for (int i = 0; i < 4 && i < hsAddr.size(); i++) begin
            checkCount++;
            if (hsAddr[i] !== expAddr[i]) begin errorCount++; $display("[TB] FAIL wrap_address %0d got %h expected %h", i, hsAddr[i], expAddr[i]); end
            checkCount++;
            if (hsData[i] !== ({6'b0, expAddr[i]} ^ 16'hA5A5)) begin errorCount++; $display("[TB] FAIL wrap_data %0d got %h expected %h", i, hsData[i], {6'b0, expAddr[i]} ^ 16'hA5A5); end
        end
        checkCount++;
        if (doneCount !== 1) begin errorCount++; $display("[TB] FAIL wrap_done_count got %0d expected 1", doneCount); end
    endtask

    task automatic test_zero_count();
        do_start(10'h055, 11'd0);
        checkCount++;
        if (rDone !== 1'b1) begin errorCount++; $display("[TB] FAIL zero_done got %b expected 1", rDone); end
        checkCount++;
        if (rBusy !== 1'b0) begin errorCount++; $display("[TB] FAIL zero_busy got %b expected 0", rBusy); end
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            checkCount++;
            if ({rValid, rBusy, rDone} !== 3'b000) begin errorCount++; $display("[TB] FAIL zero_quiet cycle %0d got %b expected 000", c, {rValid, rBusy, rDone}); end
        end
    endtask

    task automatic test_backpressure();
        ready = 1'b0;
        do_start(10'h020, 11'd2);
        repeat (2) @(negedge clk);
        for (int c = 3; c <= 8; c++) begin
            checkCount++;
            if ({rValid, rAddress, rData} !== {1'b1, 10'h020, 16'hA585}) begin
                errorCount++;
                $display("[TB] FAIL stall_hold cycle %0d got %b/%h/%h expected 1/020/a585", c, rValid, rAddress, rData);
            end
            if (c < 8) @(negedge clk);
        end
        ready = 1'b1;
        for (int c = 9; c <= 10; c++) begin
            @(negedge clk);
            checkCount++;
            if (rValid !== 1'b0) begin errorCount++; $display("[TB] FAIL stall_gap cycle %0d got %b expected 0", c, rValid); end
        end
        @(negedge clk);
        checkCount++;
        if ({rValid, rAddress, rData} !== {1'b1, 10'h021, 16'hA584}) begin
            errorCount++;
            $display("[TB] FAIL stall_second got %b/%h/%h expected 1/021/a584", rValid, rAddress, rData);
        end
        @(negedge clk);
        checkCount++;
        if ({rDone, rBusy} !== 2'b10) begin errorCount++; $display("[TB] FAIL stall_done got %b expected 10", {rDone, rBusy}); end
        @(negedge clk);
    endtask

    task automatic test_abort_and_reset();
        int dones;
        ready = 1'b1;
        do_start(10'h040, 11'd5);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkCount++;
        if ({rValid, rBusy, rDone, rData, rAddress, dispAddress} !== 39'h0) begin
            errorCount++;
            $display("[TB] FAIL abort_idle got v%b b%b d%b %h %h %h expected all zero", rValid, rBusy, rDone, rData, rAddress, dispAddress);
        end
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (rDone || rValid || rBusy) dones++;
        end
        checkCount++;
        if (dones !== 0) begin errorCount++; $display("[TB] FAIL abort_quiet got %0d active cycles expected 0", dones); end

        do_start(10'h080, 11'd5);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkCount++;
        if ({rValid, rBusy, rDone, rData, rAddress, dispAddress} !== 39'h0) begin
            errorCount++;
            $display("[TB] FAIL midreset_idle got v%b b%b d%b %h %h %h expected all zero", rValid, rBusy, rDone, rData, rAddress, dispAddress);
        end
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (rDone || rValid || rBusy) dones++;
        end
        checkCount++;
        if (dones !== 0) begin errorCount++; $display("[TB] FAIL midreset_quiet got %0d active cycles expected 0", dones); end
    endtask

    task automatic test_start_while_busy();
        ready = 1'b1;
        do_start(10'h100, 11'd3);
        run_collect(100, 6);
        checkCount++;
        if (timedOut !== 0) begin errorCount++; $display("[TB] FAIL busy_start_timeout got %0d expected 0", timedOut); end
        checkCount++;
        if (hsAddr.size() !== 3) begin errorCount++; $display("[TB] FAIL busy_start_handshakes got %0d expected 3", hsAddr.size()); end
        for (int i = 0; i < 3 && i < hsAddr.size(); i++) begin
            checkCount++;
            if (hsAddr[i] !== 10'h100 + 10'(i)) begin errorCount++; $display("[TB] FAIL busy_start_address %0d got %h expected %h", i, hsAddr[i], 10'h100 + 10'(i)); end
        end
        checkCount++;
        if (doneCount !== 1) begin errorCount++; $display("[TB] FAIL busy_start_done_count got %0d expected 1", doneCount); end
        checkCount++;
        if (rBusy !== 1'b0) begin errorCount++; $display("[TB] FAIL busy_start_idle got %b expected 0", rBusy); end
    endtask

    task automatic test_full_ram();
        int wrong;
        ready = 1'b1;
        do_start(10'h000, 11'd1024);
        run_collect(4000, 0);
        checkCount++;
        if (timedOut !== 0) begin errorCount++; $display("[TB] FAIL full_timeout got %0d expected 0", timedOut); end
        checkCount++;
        if (hsAddr.size() !== 1024) begin errorCount++; $display("[TB] FAIL full_handshakes got %0d expected 1024", hsAddr.size()); end
        wrong = 0;
        for (int i = 0; i < hsAddr.size(); i++) begin
            if (hsAddr[i] !== 10'(i) || hsData[i] !== (16'(i) ^ 16'hA5A5)) wrong++;
        end
        checkCount++;
        if (wrong !== 0) begin errorCount++; $display("[TB] FAIL full_order got %0d bad words expected 0", wrong); end
        checkCount++;
        if (doneCount !== 1) begin errorCount++; $display("[TB] FAIL full_done_count got %0d expected 1", doneCount); end
    endtask

    initial begin
        checkCount  = 0;
        errorCount  = 0;
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        ready       = 1'b0;
        baseAddress = '0;
        count       = '0;
        for (int n = 0; n < 1024; n++) mem[n] = 16'(n) ^ 16'hA5A5;
        @(negedge clk);

        test_reset();
        $display("[TB] reset done");
        test_basic();
        $display("[TB] basic done");
        test_wrap();
        $display("[TB] wrap done");
        test_zero_count();
        $display("[TB] zero count done");
        test_backpressure();
        $display("[TB] backpressure done");
        test_abort_and_reset();
        $display("[TB] abort and reset done");
        test_start_while_busy();
        $display("[TB] start while busy done");
        test_full_ram();
        $display("[TB] full ram done");

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/cram_dump_reader.md
# cram_dump_reader

Sequential reader for the debug (display) port of the CPU RAM. On a start pulse it walks a contiguous address range, drives the RAM's display address, and captures each word after the synchronous read latency. It presents each word with its address on a valid/ready stream, for a UART transmitter or display formatter. It sits between the CPU RAM's display read port and the debug output path; it never touches the CPU-side port.

## Interface
Parameters:
- p_data_width, 16, RAM word width
- p_address_width, 10, RAM address width

Ports:
- i_w_clk  in  1  the only clock; same clock as the RAM display port
- i_w_reset  in  1  synchronous, active-high reset
- i_w_start  in  1  one-cycle start pulse; ignored unless idle
- i_w_abort  in  1  stops the dump and returns to idle; no done pulse
- i_w_base_address  in  p_address_width  first address, latched on accepted start
- i_w_count  in  p_address_width+1  number of words, latched on accepted start; 0 is legal
- o_w_disp_address  out  p_address_width  to the RAM display address input; driven from a register
- i_w_disp_out  in  p_data_width  RAM display data; valid one cycle after the address is presented
- o_r_data  out  p_data_width  captured word
- o_r_address  out  p_address_width  address of o_r_data
- o_r_valid  out  1  stream valid
- i_w_ready  in  1  stream ready from the consumer
- o_r_busy  out  1  high in every state except IDLE
- o_r_done  out  1  one-cycle pulse after the last word is accepted, or after a zero-count start

## Operation
- The state machine has four states: IDLE, READ, LATCH and VALID.
- IDLE:
  - If i_w_start=1 and i_w_count≠0, latch the base address into the address register and the count into the remaining counter, then go to READ.
  - If i_w_start=1 and i_w_count=0, pulse o_r_done on the next cycle and stay in IDLE.
- READ: o_w_disp_address holds the current address for one cycle. The RAM registers its output at the end of this cycle. Next state is LATCH.
- LATCH: capture i_w_disp_out into o_r_data and the current address into o_r_address. Next state is VALID.
- VALID: o_r_valid=1. o_r_data and o_r_address stay stable while i_w_ready=0. On valid&&ready:
  - Decrement the remaining counter.
  - If the counter was 1, pulse o_r_done and go to IDLE.
  - Otherwise increment the address (modulo 2^p_address_width) and go to READ.
- Address wrap: base 0x3FE with count 4 reads 0x3FE, 0x3FF, 0x000, 0x001.
- Count 2^p_address_width dumps the whole RAM exactly once.
- Abort:
  - i_w_abort in any non-IDLE state goes to IDLE on the next edge, with o_r_valid=0 and no o_r_done.
  - Abort has priority over the ready handshake in the same cycle. That word is treated as not transferred.
- i_w_start while busy is ignored. i_w_start and i_w_abort together in IDLE: abort wins and start is ignored.
- The RAM is read-only from this block. Contents changed by the CPU mid-dump are read as they stand when each READ cycle occurs.

## Timing
- Reset values:
  - State IDLE.
  - o_r_valid=0, o_r_busy=0, o_r_done=0.
  - o_r_data=0, o_r_address=0, o_w_disp_address=0.
  - Remaining counter 0.
- Reset mid-operation aborts immediately, with no done pulse.
- Start accepted at edge 0:
  - Busy from cycle 1.
  - READ in cycle 1, LATCH in cycle 2.
  - o_r_valid first high in cycle 3.
- Each word takes 3 cycles when ready is held high. Throughput is one word per 3 cycles; the block does not pipeline.
- Done is asserted in the cycle after the final handshake. o_r_busy is 0 in that same cycle.
- o_r_valid never drops without a handshake, except on abort or reset.

## Structure
- Shared include cram_dump_defs.vh holds:
  - State encodings: IDLE=2'd0, READ=2'd1, LATCH=2'd2, VALID=2'd3.
  - The latency constant (1 cycle) for display-port reads, so it can be reused by other display-port readers.
- No sub-module is needed; the counter and address register stay inline.
- The bench instantiates this block against the existing dual-port block RAM. The CPU port writes a known pattern before the dump.

## Test plan
- Preload word[n]=n^16'hA5A5 for all n, start at base 0x010 with count 3, ready always high -> valid in cycles 3, 6 and 9, with (0x010, 0xA5B5), (0x011, 0xA5B4), (0x012, 0xA5B7); done in cycle 10.
- Base 0x3FE, count 4, ready high -> addresses 0x3FE, 0x3FF, 0x000, 0x001 in order; exactly 4 handshakes and 1 done.
- Count 0 -> o_r_done high for one cycle at cycle 1, o_r_valid never asserted, o_r_busy stays 0.
- Ready low for 5 cycles during the first VALID -> o_r_data and o_r_address stable and o_r_valid held high; the second word follows 3 cycles after ready rises.
- Abort asserted during LATCH of word 2 of 5, then i_w_reset asserted mid-dump on a second run -> both return to IDLE next edge with all outputs at their reset values and no done pulse.
- i_w_start pulsed during busy -> ignored, and the original count completes unchanged. Also, count 1024 from base 0 -> 1024 handshakes in address order, then done.
